uart_rx_ctrl: RTL and testbench

//  Sequencer/buffer for one uart_rx instance, on the same clock as the receiver.
//  - Gates uart_rx.enable and recovers it after framing/parity errors or stuck-busy timeouts.
//  - Captures each completed byte into a small FIFO.
//  - Presents FIFO contents downstream on a valid/ready stream and keeps error/drop statistics.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and fixed sequencing constants.
package uart_pkg;

  localparam int NUM_DATA_BITS = 8;
  localparam int ARM_CYCLES    = 2;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    RECOVER = 3'd4
  } rx_ctrl_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; a push on full is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_next_idx;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop      = pop & ~empty;
  assign do_push     = push & (~full | do_pop);
  assign rd_next_idx = rd_ptr[AW-1:0] + IDX_ONE;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // Head only moves on a pop or on the first push into an empty FIFO, so it
      // stays stable while the consumer stalls.
      if (do_pop) begin
        if (count > PTR_ONE) head <= mem[rd_next_idx];
        else if (do_push)    head <= push_data;
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer and byte buffer for one uart_rx: gates its enable, recovers from
// errors/stuck-busy, buffers bytes and streams them out with statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W         = NUM_DATA_BITS,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_W          = 8,
  parameter int RECOVER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              baud,
  input  logic              rst,
  input  logic              cfg_enable,
  input  logic              stat_clr,
  output logic              rx_enable,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_busy,
  input  logic              rx_error,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [2:0]        ctrl_state
);

  localparam int PH_W = $clog2(ARM_CYCLES + RECOVER_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]  ARM_LAST = PH_W'(ARM_CYCLES - 1);
  localparam logic [PH_W-1:0]  REC_LAST = PH_W'(RECOVER_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rx_ctrl_state_t  state;
  rx_ctrl_state_t  state_n;
  logic [PH_W-1:0] phase;
  logic [TO_W-1:0] busy_cnt;
  logic            busy_q;
  logic            err_q;
  logic            active;
  logic            byte_evt;
  logic            err_evt;
  logic            timeout;
  logic            push;
  logic            err_inc;
  logic            pop;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;

  assign active     = (state == RUN) || (state == DRAIN);
  assign rx_enable  = (state == ARM) || active;
  assign ctrl_state = state;

  // rx_done is sticky in uart_rx, so a byte is the falling edge of busy with done set.
  assign byte_evt = busy_q & ~rx_busy & rx_done;
  assign err_evt  = ~err_q & rx_error;
  assign timeout  = active & rx_busy & (busy_cnt == TO_LAST);

  always_comb begin
    state_n = state;
    push    = 1'b0;
    err_inc = 1'b0;
    case (state)
      OFF: begin
        if (cfg_enable) state_n = ARM;
      end
      ARM: begin
        if (!cfg_enable)            state_n = OFF;
        else if (phase == ARM_LAST) state_n = RUN;
      end
      RUN: begin
        push = byte_evt;
        if (err_evt || timeout) begin
          err_inc = 1'b1;
          state_n = RECOVER;
        end else if (!cfg_enable) begin
          state_n = rx_busy ? DRAIN : OFF;
        end
      end
      DRAIN: begin
        push    = byte_evt;
        err_inc = err_evt | timeout;
        if (byte_evt || err_evt || timeout) state_n = OFF;
      end
      RECOVER: begin
        if (phase == REC_LAST) state_n = cfg_enable ? ARM : OFF;
      end
      default: state_n = OFF;
    endcase
  end

  always_ff @(posedge baud) begin
    if (rst) begin
      state    <= OFF;
      phase    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)                       phase <= '0;
      else if (state == ARM || state == RECOVER)  phase <= phase + PH_ONE;
      // Edge copies fall back to 0 while uart_rx is held in reset.
      busy_q   <= rx_enable & rx_busy;
      err_q    <= rx_enable & rx_error;
      busy_cnt <= (active && rx_busy && !timeout) ? busy_cnt + TO_ONE : '0;
    end
  end

  // Stream: a byte transfers on a cycle where m_valid and m_ready are both high;
  // m_data/m_valid do not change while m_valid=1 and m_ready=0.
  assign pop  = m_valid & m_ready;
  assign drop = push & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (baud),
    .rst       (rst),
    .push      (push),
    .push_data (rx_data),
    .pop       (pop),
    .head      (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid = ~fifo_empty;

  always_ff @(posedge baud) begin
    if (rst || stat_clr) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + CNT_ONE;
      if (err_inc && err_cnt != '1) err_cnt  <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: cycle table for bring-up/error recovery, then
// hand sequences for overflow, timeout, drain and mid-byte reset.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          baud = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic          stat_clr;
  logic          rx_enable;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          rx_busy;
  logic          rx_error;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          overflow;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] drop_cnt;
  logic [2:0]    ctrl_state;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          en, busy, done;
    logic [DW-1:0] data;
    logic          err, ready, clr;
    logic [2:0]    st;
    logic          rxe, mv;
    logic [DW-1:0] md;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t vq[$];

  // ---------------- clock / reset ----------------
  always #5 baud = ~baud;

  uart_rx_ctrl dut (
    .baud       (baud),
    .rst        (rst),
    .cfg_enable (cfg_enable),
    .stat_clr   (stat_clr),
    .rx_enable  (rx_enable),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .rx_error   (rx_error),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .overflow   (overflow),
    .err_cnt    (err_cnt),
    .drop_cnt   (drop_cnt),
    .ctrl_state (ctrl_state)
  );

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, busy, done, input logic [DW-1:0] data,
                              input logic err, ready, clr, input logic [2:0] st,
                              input logic rxe, mv, input logic [DW-1:0] md,
                              input logic [CW-1:0] ec);
    vec_t v;
    v.en = en; v.busy = busy; v.done = done; v.data = data; v.err = err;
    v.ready = ready; v.clr = clr; v.st = st; v.rxe = rxe; v.mv = mv; v.md = md; v.ec = ec;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [DW-1:0] data, input logic err, input logic done_flag,
                           input logic pop, input logic clr);
    @(negedge baud);
    rx_busy = 1'b1; rx_done = 1'b0; rx_error = 1'b0;
    repeat (2) @(negedge baud);
    rx_busy = 1'b0; rx_done = done_flag; rx_data = data; rx_error = err;
    m_ready = pop; stat_clr = clr;
    @(negedge baud);
    m_ready = 1'b0; stat_clr = 1'b0; rx_error = 1'b0;
  endtask

  task automatic wait_state(input rx_ctrl_state_t target, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge baud);
      if (ctrl_state == target) hit = 1'b1;
    end
    check(name, hit, 1);
  endtask

  task automatic drain_check(input string name);
    logic [DW-1:0] e;
    while (exp_q.size() > 0) begin
      @(negedge baud);
      e = exp_q.pop_front();
      check({name, "_valid"}, m_valid, 1);
      check({name, "_data"}, m_data, e);
      m_ready = 1'b1;
    end
    @(negedge baud);
    m_ready = 1'b0;
    check({name, "_empty"}, m_valid, 0);
  endtask

  // ---------------- test body ----------------
  initial begin
    int  n;
    bit  hit;

    // en busy done data err rdy clr | state rxe mv md ec
    vq.push_back(mk(1,0,0,8'h00,0,1,0, OFF==OFF ? ARM : ARM, 1,0,8'h00,0));
    vq.push_back(mk(1,0,0,8'h00,0,1,0, ARM,     1,0,8'h00,0));
    vq.push_back(mk(1,0,0,8'h00,0,1,0, RUN,     1,0,8'h00,0));
    vq.push_back(mk(1,1,0,8'h00,0,1,0, RUN,     1,0,8'h00,0));
    vq.push_back(mk(1,1,0,8'h00,0,1,0, RUN,     1,0,8'h00,0));
    vq.push_back(mk(1,0,1,8'h5A,0,1,0, RUN,     1,1,8'h5A,0));
    vq.push_back(mk(1,0,1,8'h5A,0,1,0, RUN,     1,0,8'h5A,0));
    vq.push_back(mk(1,1,0,8'h5A,0,1,0, RUN,     1,0,8'h5A,0));
    vq.push_back(mk(1,0,1,8'hC3,0,1,0, RUN,     1,1,8'hC3,0));
    vq.push_back(mk(1,0,1,8'hC3,0,0,0, RUN,     1,1,8'hC3,0));
    vq.push_back(mk(1,0,1,8'hC3,0,1,0, RUN,     1,0,8'hC3,0));
    vq.push_back(mk(1,1,0,8'hC3,0,1,0, RUN,     1,0,8'hC3,0));
    vq.push_back(mk(1,0,0,8'h11,1,1,0, RECOVER, 0,0,8'hC3,1));
    vq.push_back(mk(1,0,0,8'h11,0,1,0, RECOVER, 0,0,8'hC3,1));
    vq.push_back(mk(1,0,0,8'h11,0,1,0, RECOVER, 0,0,8'hC3,1));
    vq.push_back(mk(1,0,0,8'h11,0,1,0, RECOVER, 0,0,8'hC3,1));
    vq.push_back(mk(1,0,0,8'h11,0,1,0, ARM,     1,0,8'hC3,1));
    vq.push_back(mk(1,0,0,8'h11,0,1,0, ARM,     1,0,8'hC3,1));
    vq.push_back(mk(1,0,0,8'h11,0,1,0, RUN,     1,0,8'hC3,1));
    vq.push_back(mk(1,1,0,8'h11,0,1,0, RUN,     1,0,8'hC3,1));
    vq.push_back(mk(1,0,1,8'h22,0,1,0, RUN,     1,1,8'h22,1));
    vq.push_back(mk(1,0,1,8'h22,0,1,0, RUN,     1,0,8'h22,1));
    vq.push_back(mk(1,1,0,8'h22,0,1,0, RUN,     1,0,8'h22,1));
    vq.push_back(mk(1,0,1,8'h33,1,0,0, RECOVER, 0,1,8'h33,2));
    vq.push_back(mk(0,0,0,8'h33,0,0,0, RECOVER, 0,1,8'h33,2));
    vq.push_back(mk(0,0,0,8'h33,0,0,0, RECOVER, 0,1,8'h33,2));
    vq.push_back(mk(0,0,0,8'h33,0,0,0, RECOVER, 0,1,8'h33,2));
    vq.push_back(mk(0,0,0,8'h33,0,0,0, OFF,     0,1,8'h33,2));
    vq.push_back(mk(0,0,0,8'h33,0,1,0, OFF,     0,0,8'h33,2));

    rst = 1'b1; cfg_enable = 1'b0; stat_clr = 1'b0; rx_data = '0;
    rx_done = 1'b0; rx_busy = 1'b0; rx_error = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge baud);
    #1;
    check("rst_state", ctrl_state, OFF);
    check("rst_rx_enable", rx_enable, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(negedge baud);
    rst = 1'b0;

    // Bring-up, two bytes, parity error recovery, byte+error together.
    foreach (vq[i]) begin
      @(negedge baud);
      cfg_enable = vq[i].en; rx_busy = vq[i].busy; rx_done = vq[i].done;
      rx_data = vq[i].data; rx_error = vq[i].err; m_ready = vq[i].ready;
      stat_clr = vq[i].clr;
      @(posedge baud);
      #1;
      check($sformatf("v%0d_state", i), ctrl_state, vq[i].st);
      check($sformatf("v%0d_rx_enable", i), rx_enable, vq[i].rxe);
      check($sformatf("v%0d_m_valid", i), m_valid, vq[i].mv);
      if (vq[i].mv) check($sformatf("v%0d_m_data", i), m_data, vq[i].md);
      check($sformatf("v%0d_err_cnt", i), err_cnt, vq[i].ec);
    end
    @(negedge baud);
    m_ready = 1'b0; rx_done = 1'b0;

    // Overflow: 18 bytes into a 16-deep FIFO with no consumer.
    cfg_enable = 1'b1;
    wait_state(RUN, 10, "ovf_arm");
    for (int b = 0; b < 18; b++) send_byte(8'(b), 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovf_overflow", overflow, 1);
    check("ovf_drop_cnt", drop_cnt, 2);
    check("ovf_head", m_data, 8'h00);
    stat_clr = 1'b1;
    @(negedge baud);
    stat_clr = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_drop_cnt", drop_cnt, 0);
    // Push onto a full FIFO while the head is popped: accepted, nothing dropped.
    send_byte(8'h12, 1'b0, 1'b1, 1'b1, 1'b0);
    check("fullpp_drop_cnt", drop_cnt, 0);
    check("fullpp_overflow", overflow, 0);
    for (int b = 1; b < 16; b++) exp_q.push_back(8'(b));
    exp_q.push_back(8'h12);
    drain_check("ovf_drain");

    // Error and stat_clr in the same cycle: the clear wins.
    send_byte(8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clrwin_err_cnt", err_cnt, 0);
    check("clrwin_state", ctrl_state, RECOVER);
    check("clrwin_no_push", m_valid, 0);
    wait_state(RUN, 20, "clrwin_rearm");

    // Stuck busy: timeout after 256 consecutive busy cycles.
    @(negedge baud);
    rx_done = 1'b0; rx_busy = 1'b1;
    n = 0; hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge baud);
      #1;
      n++;
      if (ctrl_state == RECOVER) hit = 1'b1;
    end
    check("to_cycles", n, 256);
    check("to_err_cnt", err_cnt, 1);
    check("to_rx_enable", rx_enable, 0);
    @(negedge baud);
    rx_busy = 1'b0;
    n = 1; hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge baud);
      #1;
      if (ctrl_state == RECOVER) n++;
      else hit = 1'b1;
    end
    check("to_recover_len", n, 4);
    check("to_then_arm", ctrl_state, ARM);
    wait_state(RUN, 10, "to_rearm");

    // Disable mid-byte: finish the byte in DRAIN, then OFF.
    @(negedge baud);
    rx_busy = 1'b1;
    @(negedge baud);
    cfg_enable = 1'b0;
    @(posedge baud);
    #1;
    check("drain_state", ctrl_state, DRAIN);
    check("drain_rx_enable", rx_enable, 1);
    @(negedge baud);
    rx_busy = 1'b0; rx_done = 1'b1; rx_data = 8'h7E;
    @(posedge baud);
    #1;
    check("drain_off", ctrl_state, OFF);
    check("drain_off_rx_enable", rx_enable, 0);
    check("drain_byte", m_data, 8'h7E);
    @(negedge baud);
    rx_done = 1'b0;
    exp_q.push_back(8'h7E);
    drain_check("drain_pop");

    // Reset mid-byte with three bytes buffered.
    cfg_enable = 1'b1;
    wait_state(RUN, 10, "rst_arm");
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rstmid_pre_valid", m_valid, 1);
    rx_busy = 1'b1; rx_done = 1'b0;
    @(negedge baud);
    rst = 1'b1;
    @(posedge baud);
    #1;
    check("rstmid_m_valid", m_valid, 0);
    check("rstmid_m_data", m_data, 0);
    check("rstmid_err_cnt", err_cnt, 0);
    check("rstmid_drop_cnt", drop_cnt, 0);
    check("rstmid_state", ctrl_state, OFF);
    check("rstmid_rx_enable", rx_enable, 0);
    @(negedge baud);
    rst = 1'b0; cfg_enable = 1'b0; rx_busy = 1'b0;
    @(negedge baud);
    check("rstmid_stays_off", ctrl_state, OFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
